// File: rtl/dma_bus_host.sv
`default_nettype none
// ============================================================================
//  Module   : dma_bus_host
//  Purpose  : Single-channel memory-to-memory DMA engine. It is programmed
//             through a small register port and copies LEN 32-bit words from
//             SRC to DST as a bus initiator. It keeps one transaction
//             outstanding at a time and raises a level interrupt when done.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   device_*           register port (req/addr/we/be/wdata -> rvalid/rdata)
//   host_*             initiator port (req/gnt, addr/we/be/wdata, rvalid/
//                      rdata/err)
//   irq_o              DONE & IRQ_EN level interrupt
// ============================================================================
module dma_bus_host #(
  parameter int AddrWidth  = 32,
  parameter int LenWidth   = 16,
  parameter int RegAddrLsb = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [31:0]          device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [31:0]          device_rdata_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [31:0]          host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [31:0]          host_rdata_i,
  input  logic                 host_err_i,
  output logic                 irq_o
);

  localparam int c_IDXW = 5 - RegAddrLsb;
  localparam logic [c_IDXW-1:0] c_REG_SRC    = c_IDXW'(0);
  localparam logic [c_IDXW-1:0] c_REG_DST    = c_IDXW'(1);
  localparam logic [c_IDXW-1:0] c_REG_LEN    = c_IDXW'(2);
  localparam logic [c_IDXW-1:0] c_REG_CTRL   = c_IDXW'(3);
  localparam logic [c_IDXW-1:0] c_REG_REMAIN = c_IDXW'(4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_t;

  state_t                r_state;
  logic [AddrWidth-1:0]  r_src;
  logic [AddrWidth-1:0]  r_dst;
  logic [LenWidth-1:0]   r_len;
  logic [AddrWidth-1:0]  r_cur_src;
  logic [AddrWidth-1:0]  r_cur_dst;
  logic [LenWidth-1:0]   r_remain;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_irq_en;
  logic                  r_abort_pend;
  logic                  r_dev_rvalid;
  logic [31:0]           r_dev_rdata;
  logic                  r_host_req;
  logic                  r_host_we;
  logic [AddrWidth-1:0]  r_host_addr;
  // Doubles as the read-data buffer between RD_WAIT and WR_REQ.
  logic [31:0]           r_host_wdata;

  // Per-byte merge of register write data into an existing value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [c_IDXW-1:0]    w_idx;
  logic                 w_in_range;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_ctrl_cmd;
  logic                 w_start;
  logic                 w_abort;
  logic                 w_abort_now;
  logic [AddrWidth-1:0] w_src_merged;
  logic [AddrWidth-1:0] w_dst_merged;
  logic [LenWidth-1:0]  w_len_merged;
  logic [31:0]          w_rdata;
  logic                 w_unused;

  assign w_idx        = device_addr_i[4:RegAddrLsb];
  assign w_in_range   = (device_addr_i[11:5] == 7'd0);
  assign w_wr         = device_req_i & device_we_i & w_in_range;
  assign w_rd         = device_req_i & ~device_we_i;
  assign w_ctrl_cmd   = w_wr & (w_idx == c_REG_CTRL) & device_be_i[0];
  assign w_start      = w_ctrl_cmd & device_wdata_i[0] & ~r_busy;
  assign w_abort      = w_ctrl_cmd & device_wdata_i[5] & r_busy;
  // An abort accepted earlier in this transfer, or one arriving right now.
  assign w_abort_now  = w_abort | r_abort_pend;
  assign w_src_merged = AddrWidth'(f_merge(32'(r_src), device_wdata_i, device_be_i));
  assign w_dst_merged = AddrWidth'(f_merge(32'(r_dst), device_wdata_i, device_be_i));
  assign w_len_merged = LenWidth'(f_merge(32'(r_len), device_wdata_i, device_be_i));

  assign w_unused = ^{device_addr_i[AddrWidth-1:12], device_addr_i[RegAddrLsb-1:0],
                      w_src_merged[1:0], w_dst_merged[1:0]};

  always_comb begin
    w_rdata = 32'd0;
    if (w_in_range) begin
      case (w_idx)
        c_REG_SRC:    w_rdata = 32'(r_src);
        c_REG_DST:    w_rdata = 32'(r_dst);
        c_REG_LEN:    w_rdata = 32'(r_len);
        c_REG_CTRL:   w_rdata = {26'd0, 1'b0, r_irq_en, r_err, r_done, r_busy, 1'b0};
        c_REG_REMAIN: w_rdata = 32'(r_remain);
        default:      w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_cur_src    <= '0;
      r_cur_dst    <= '0;
      r_remain     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_irq_en     <= 1'b0;
      r_abort_pend <= 1'b0;
      r_dev_rvalid <= 1'b0;
      r_dev_rdata  <= 32'd0;
      r_host_req   <= 1'b0;
      r_host_we    <= 1'b0;
      r_host_addr  <= '0;
      r_host_wdata <= 32'd0;
    end else begin
      r_dev_rvalid <= device_req_i;
      r_dev_rdata  <= w_rd ? w_rdata : 32'd0;

      // Configuration is frozen while a transfer is running.
      if (w_wr && !r_busy) begin
        if (w_idx == c_REG_SRC) r_src <= {w_src_merged[AddrWidth-1:2], 2'b00};
        if (w_idx == c_REG_DST) r_dst <= {w_dst_merged[AddrWidth-1:2], 2'b00};
        if (w_idx == c_REG_LEN) r_len <= w_len_merged;
      end
      if (w_ctrl_cmd) begin
        r_irq_en <= device_wdata_i[4];
        if (device_wdata_i[2]) r_done <= 1'b0;
        if (device_wdata_i[3]) r_err  <= 1'b0;
      end

      // FSM updates come after the W1C logic so a hardware DONE/ERR set
      // in the same cycle overrides a software clear.
      case (r_state)
        S_IDLE: begin
          if (r_busy) begin
            // Only reachable for a zero-length START: finish without traffic.
            r_busy <= 1'b0;
            if (!w_abort) r_done <= 1'b1;
          end else if (w_start) begin
            r_cur_src <= r_src;
            r_cur_dst <= r_dst;
            r_remain  <= r_len;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            if (r_len != '0) begin
              r_state     <= S_RD_REQ;
              r_host_req  <= 1'b1;
              r_host_we   <= 1'b0;
              r_host_addr <= r_src;
            end
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          if (host_gnt_i) begin
            r_host_req   <= 1'b0;
            r_abort_pend <= w_abort;
            r_state      <= (r_state == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
          end else if (w_abort) begin
            r_host_req <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          if (host_rvalid_i) begin
            r_abort_pend <= 1'b0;
            if (host_err_i) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_host_wdata <= host_rdata_i;
              if (w_abort_now) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state     <= S_WR_REQ;
                r_host_req  <= 1'b1;
                r_host_we   <= 1'b1;
                r_host_addr <= r_cur_dst;
              end
            end
          end else if (w_abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (host_rvalid_i) begin
            r_abort_pend <= 1'b0;
            if (host_err_i) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cur_src <= r_cur_src + AddrWidth'(4);
              r_cur_dst <= r_cur_dst + AddrWidth'(4);
              r_remain  <= r_remain - LenWidth'(1);
              if (w_abort_now) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else if (r_remain == LenWidth'(1)) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state     <= S_RD_REQ;
                r_host_req  <= 1'b1;
                r_host_we   <= 1'b0;
                r_host_addr <= r_cur_src + AddrWidth'(4);
              end
            end
          end else if (w_abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign device_rvalid_o = r_dev_rvalid;
  assign device_rdata_o  = r_dev_rdata;
  assign host_req_o      = r_host_req;
  assign host_addr_o     = r_host_addr;
  assign host_we_o       = r_host_we;
  // Full-word transfers only; qualified by req so the bus is quiet in reset.
  assign host_be_o       = {4{r_host_req}};
  assign host_wdata_o    = r_host_wdata;
  assign irq_o           = r_done & r_irq_en;

endmodule
`default_nettype wire
